// File: rtl/chacha_keystream_xor_if.sv
// Bus bundle for chacha_keystream_xor: core block read port, plaintext in, ciphertext out.
// slave is the keystream XOR block; master is the surrounding core/producer/consumer.
interface chacha_keystream_xor_if #(
  parameter int CNT_W = 32
);
  logic             core_blk_ready;
  logic             core_rd_blk;
  logic [7:0]       core_data;
  logic [7:0]       pt_data;
  logic             pt_valid;
  logic             pt_last;
  logic             pt_ready;
  logic [7:0]       ct_data;
  logic             ct_valid;
  logic             ct_last;
  logic             ct_ready;
  logic [CNT_W-1:0] blk_count;

  modport master (
    output core_blk_ready, core_data, pt_data, pt_valid, pt_last, ct_ready,
    input  core_rd_blk, pt_ready, ct_data, ct_valid, ct_last, blk_count
  );

  modport slave (
    input  core_blk_ready, core_data, pt_data, pt_valid, pt_last, ct_ready,
    output core_rd_blk, pt_ready, ct_data, ct_valid, ct_last, blk_count
  );
endinterface

// File: rtl/chacha_keystream_xor.sv
// Fetches a 64-byte keystream block from the chacha core and XORs it onto a byte stream.
// Optional: CHACHA_XOR_LAST_FLUSH_EN drops the block remainder after a pt_last byte.
//
// state | meaning
// IDLE  | no block held; request one when the core has it ready
// FETCH | latency wait, then capture 64 keystream bytes one per cycle
// SERVE | XOR buffered keystream onto accepted plaintext bytes
module chacha_keystream_xor #(
  parameter int CNT_W     = 32,
  parameter int FETCH_LAT = 0
) (
  input logic                clk,
  input logic                rst,
  chacha_keystream_xor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SERVE} state_t;

  localparam logic [1:0]       LAT     = 2'(FETCH_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       ks_buf [64];
  logic [5:0]       cap_idx_q, rd_idx_q;
  logic [1:0]       lat_cnt_q;
  logic [CNT_W-1:0] blk_count_q;
  logic             rd_blk_q;
  logic [7:0]       ct_data_q;
  logic             ct_valid_q, ct_last_q;
  logic             cap_en, pt_ready, pt_hs, cap_done, serve_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.core_blk_ready) state_d = FETCH;
      FETCH:   if (cap_done) state_d = SERVE;
      SERVE:   if (serve_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_en   = 1'b0;
    pt_ready = 1'b0;
    case (state_q)
      FETCH:   cap_en = (lat_cnt_q == 2'd0);
      SERVE:   pt_ready = !ct_valid_q | bus.ct_ready;
      default: ;
    endcase
  end

  assign pt_hs    = bus.pt_valid & pt_ready;
  assign cap_done = cap_en & (cap_idx_q == 6'd63);
`ifdef CHACHA_XOR_LAST_FLUSH_EN
  assign serve_done = pt_hs & ((rd_idx_q == 6'd63) | bus.pt_last);
`else
  assign serve_done = pt_hs & (rd_idx_q == 6'd63);
`endif

  // Keystream buffer carries no reset; a block is only read after a full capture.
  always_ff @(posedge clk) begin
    if (cap_en) ks_buf[cap_idx_q] <= bus.core_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_blk_q    <= 1'b0;
      lat_cnt_q   <= 2'd0;
      cap_idx_q   <= 6'd0;
      rd_idx_q    <= 6'd0;
      blk_count_q <= '0;
      ct_data_q   <= 8'd0;
      ct_valid_q  <= 1'b0;
      ct_last_q   <= 1'b0;
    end else begin
      // Request pulse coincides with the first FETCH cycle.
      rd_blk_q <= (state_q == IDLE) & bus.core_blk_ready;

      if (state_q == IDLE)
        lat_cnt_q <= LAT;
      else if (state_q == FETCH && lat_cnt_q != 2'd0)
        lat_cnt_q <= lat_cnt_q - 2'd1;

      if (state_q == IDLE)
        cap_idx_q <= 6'd0;
      else if (cap_en)
        cap_idx_q <= cap_idx_q + 6'd1;

      if (cap_done) begin
        blk_count_q <= blk_count_q + CNT_ONE;
        rd_idx_q    <= 6'd0;
      end else if (pt_hs) begin
        rd_idx_q <= rd_idx_q + 6'd1;
      end

      if (pt_hs) begin
        ct_data_q  <= bus.pt_data ^ ks_buf[rd_idx_q];
        ct_last_q  <= bus.pt_last;
        ct_valid_q <= 1'b1;
      end else if (bus.ct_ready) begin
        ct_valid_q <= 1'b0;
      end
    end
  end

  assign bus.core_rd_blk = rd_blk_q;
  assign bus.pt_ready    = pt_ready;
  assign bus.ct_data     = ct_data_q;
  assign bus.ct_valid    = ct_valid_q;
  assign bus.ct_last     = ct_last_q;
  assign bus.blk_count   = blk_count_q;

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Directed bench for chacha_keystream_xor with a model core emitting 8'hA0+k per block.
// Expected values for the flush scenario follow CHACHA_XOR_LAST_FLUSH_EN.
module tb_chacha_keystream_xor;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chacha_keystream_xor_if #(.CNT_W(CNT_W)) bus ();

  chacha_keystream_xor #(.CNT_W(CNT_W), .FETCH_LAT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model core: byte 0 during the pulse cycle, then one byte per cycle.
  int k_q = 0;
  always @(posedge clk) begin
    if (bus.core_rd_blk) k_q <= 1;
    else                 k_q <= k_q + 1;
  end
  assign bus.core_data = bus.core_rd_blk ? 8'hA0 : 8'(8'hA0 + k_q);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string tag);
    for (int n = 0; n < 400; n++) begin
      step();
      if (bus.core_rd_blk) break;
    end
    check(tag, 32'(bus.core_rd_blk), 32'd1);
  endtask

  task automatic send_one(input logic [7:0] d, input logic l,
                          output logic [7:0] got, output logic gotl);
    bus.ct_ready = 1'b1;
    bus.pt_data  = d;
    bus.pt_last  = l;
    bus.pt_valid = 1'b1;
    #1;
    for (int n = 0; n < 400; n++) begin
      if (bus.pt_ready) break;
      @(posedge clk);
      #1;
    end
    check("send_pt_ready", 32'(bus.pt_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.pt_valid = 1'b0;
    bus.pt_last  = 1'b0;
    check("send_ct_valid", 32'(bus.ct_valid), 32'd1);
    got  = bus.ct_data;
    gotl = bus.ct_last;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] got, held;
  logic       gotl, seen15;
  int         pulses, sent, rcvd;

  initial begin
    rst                = 1'b1;
    bus.core_blk_ready = 1'b0;
    bus.pt_data        = 8'd0;
    bus.pt_valid       = 1'b0;
    bus.pt_last        = 1'b0;
    bus.ct_ready       = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_rd_blk",   32'(bus.core_rd_blk), 32'd0);
    check("rst_pt_ready", 32'(bus.pt_ready),    32'd0);
    check("rst_ct_valid", 32'(bus.ct_valid),    32'd0);
    check("rst_ct_data",  32'(bus.ct_data),     32'd0);
    check("rst_ct_last",  32'(bus.ct_last),     32'd0);
    check("rst_blk_cnt",  32'(bus.blk_count),   32'd0);

    // 1: single fetch
    rst = 1'b0;
    bus.core_blk_ready = 1'b1;
    wait_pulse("t1_pulse");
    pulses = 1;
    repeat (64) begin
      step();
      if (bus.core_rd_blk) pulses++;
    end
    check("t1_pulses",   32'(pulses),        32'd1);
    check("t1_blk_cnt",  32'(bus.blk_count), 32'd1);
    check("t1_pt_ready", 32'(bus.pt_ready),  32'd1);

    // 2: full block of zero plaintext at full rate
    bus.pt_valid = 1'b1;
    bus.pt_data  = 8'h00;
    bus.ct_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      check("t2_ct", {23'd0, bus.ct_valid, bus.ct_data}, {23'd0, 1'b1, 8'(8'hA0 + i)});
    end
    bus.pt_valid = 1'b0;
    check("t2_no_same_cycle_req", 32'(bus.core_rd_blk), 32'd0);
    step();
    check("t2_repulse", 32'(bus.core_rd_blk), 32'd1);
    check("t2_drain",   32'(bus.ct_valid),    32'd0);
    bus.core_blk_ready = 1'b0;
    repeat (64) step();
    check("t2_blk_cnt", 32'(bus.blk_count), 32'd2);

    // 3: backpressure mid-stream
    sent = 0;
    rcvd = 0;
    held = 8'd0;
    for (int cyc = 0; cyc < 400 && rcvd < 64; cyc++) begin
      bus.ct_ready = !(cyc >= 20 && cyc < 30);
      bus.pt_valid = (sent < 64);
      bus.pt_data  = 8'(sent * 7 + 3);
      #1;
      if (bus.ct_valid && !bus.ct_ready) begin
        check("t3_stall_pt_ready", 32'(bus.pt_ready), 32'd0);
        if (cyc > 20) check("t3_hold", 32'(bus.ct_data), 32'(held));
        held = bus.ct_data;
      end
      if (bus.ct_valid && bus.ct_ready) begin
        if (exp_q.size() == 0) check("t3_q_nonempty", 32'(exp_q.size()), 32'd1);
        else                   check("t3_ct", 32'(bus.ct_data), 32'(exp_q.pop_front()));
        rcvd++;
      end
      if (bus.pt_valid && bus.pt_ready) begin
        exp_q.push_back(bus.pt_data ^ 8'(8'hA0 + sent));
        sent++;
      end
      step();
    end
    bus.pt_valid = 1'b0;
    bus.ct_ready = 1'b1;
    check("t3_sent", 32'(sent), 32'd64);
    check("t3_rcvd", 32'(rcvd), 32'd64);

    // 4: reset mid-fetch
    bus.core_blk_ready = 1'b1;
    wait_pulse("t4_pulse");
    repeat (30) step();
    rst = 1'b1;
    #1;
    check("t4_rd_blk",   32'(bus.core_rd_blk), 32'd0);
    check("t4_pt_ready", 32'(bus.pt_ready),    32'd0);
    check("t4_ct_valid", 32'(bus.ct_valid),    32'd0);
    check("t4_ct_data",  32'(bus.ct_data),     32'd0);
    check("t4_blk_cnt",  32'(bus.blk_count),   32'd0);
    step();
    rst = 1'b0;
    wait_pulse("t4_refetch");
    repeat (64) step();
    check("t4_blk_cnt1", 32'(bus.blk_count), 32'd1);
    send_one(8'h5A, 1'b0, got, gotl);
    check("t4_first_ct", 32'(got), 32'hFA);

    // 5: pt_last mid-block
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_pulse("t5_pulse");
    repeat (64) step();
    for (int i = 0; i < 6; i++) begin
      send_one(8'(8'h10 + i), (i == 5), got, gotl);
      check("t5_msg_ct", 32'(got), 32'((8'h10 + i) ^ (8'hA0 + i)));
      check("t5_msg_last", 32'(gotl), 32'(i == 5));
    end
    send_one(8'h00, 1'b0, got, gotl);
`ifdef CHACHA_XOR_LAST_FLUSH_EN
    check("t5_next_ct",  32'(got),           32'hA0);
    check("t5_blk_cnt",  32'(bus.blk_count), 32'd2);
`else
    check("t5_next_ct",  32'(got),           32'hA6);
    check("t5_blk_cnt",  32'(bus.blk_count), 32'd1);
`endif

    // 6: blk_count wrap with CNT_W=4
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.core_blk_ready = 1'b1;
    bus.pt_valid = 1'b1;
    bus.pt_data  = 8'h00;
    bus.pt_last  = 1'b0;
    bus.ct_ready = 1'b1;
    pulses = 0;
    seen15 = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      if (bus.core_rd_blk) pulses++;
      if (bus.blk_count == 4'hF) seen15 = 1'b1;
      if (seen15 && bus.blk_count == 4'h0) break;
    end
    bus.pt_valid = 1'b0;
    check("t6_seen_all_ones", 32'(seen15),        32'd1);
    check("t6_wrapped",       32'(bus.blk_count), 32'd0);
    check("t6_pulses",        32'(pulses),        32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
